id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  Decode-to-execute boundary directly downstream of the register file. Drives the register
//  file read addresses from the IF/ID fields and applies a same-cycle write-back bypass to
//  ReadData1/2. Detects load-use hazards and latches operands, immediate and control into
//  the ID/EX pipeline register, with stall, bubble and flush handling.
// PARAMETERS
//  CTRL_W       12   width of the decoded control bundle carried to EX
//  MEMREAD_BIT  3    bit index of MemRead inside the control bundle
//  CNT_W        16   width of the saturating stall-cycle counter
// PORTS
//  Clk              in   1       clock; all state updates on rising edge
//  Rst              in   1       asynchronous, active-high reset
//  InValid          in   1       IF/ID holds a real instruction
//  Rs, Rt, Rd       in   5 each  IF/ID register fields
//  UsesRt           in   1       instruction reads Rt as a source
//  Imm              in   32      sign/zero-extended immediate from decode
//  CtrlIn           in   CTRL_W  decoded control bundle
//  ReadRegister1/2  out  5       register file read addresses (= Rs / Rt, combinational)
//  ReadData1/2      in   32      register file read data
//  WB_RegWrite      in   1       write-back stage is writing this cycle
//  WB_WriteRegister in   5       write-back destination
//  WB_WriteData     in   32      write-back data
//  ExHold           in   1       EX is busy (multi-cycle op); ID/EX must hold
//  Flush            in   1       taken branch/jump; kill the instruction entering EX
//  Stall            out  1       upstream (PC, IF/ID) must hold this cycle
//  EX_Valid         out  1       ID/EX holds a real instruction
//  EX_Rs/EX_Rt/EX_Rd out 5 each  registered register fields
//  EX_A, EX_B       out  32      registered (bypassed) operands
//  EX_Imm           out  32      registered immediate
//  EX_Ctrl          out  CTRL_W  registered control; all-zero for a bubble
//  StallCount       out  CNT_W   number of cycles with Stall=1, saturating
// BEHAVIOUR
//  Reset: all EX_* outputs 0, EX_Valid=0, StallCount=0, state=RUN. Takes effect immediately.
//  Bypass (combinational):
//   - opA = WB_WriteData if WB_RegWrite && WB_WriteRegister!=0 && WB_WriteRegister==Rs,
//     else ReadData1.
//   - opB is the same rule with Rt / ReadData2.
//   - Register 0 always yields 0, regardless of ReadData or WB.
//  Hazard (combinational):
//   - haz = InValid && EX_Valid && EX_Ctrl[MEMREAD_BIT] && EX_Rt!=0
//     && (EX_Rt==Rs || (UsesRt && EX_Rt==Rt)).
//  Stall = !Flush && (ExHold || haz).
//  Register update priority (rising edge): Flush > ExHold > haz > load.
//   - Flush: load bubble (EX_Valid=0, EX_Ctrl=0, other fields don't-care; drive 0).
//   - ExHold: all ID/EX registers keep their value.
//   - haz: load bubble; the instruction stays in IF/ID via Stall.
//   - else: load {InValid, Rs, Rt, Rd, opA, opB, Imm, InValid ? CtrlIn : 0}.
//  Latency: 1 cycle from IF/ID to EX_*.
//  FSM (2 states):
//   - RUN -> BUBBLE when haz && !ExHold && !Flush.
//   - BUBBLE -> RUN next cycle unconditionally. The bubble clears haz, so a load-use
//     costs exactly one stall cycle; back-to-back hazards are impossible.
//  StallCount: increments on each cycle with Stall=1; holds at 2^CNT_W-1.
//  Simultaneous events:
//   - Flush+ExHold: flush wins and EX_Valid drops.
//   - WB write to the same reg as a hazard source: bypass still applies to the value
//     latched after the bubble.
//  Reset mid-stall: returns to RUN with an empty ID/EX; no pending stall survives.
// TESTING
//  1. Pass-through:
//     - Stimulus: Rs=8, Rt=9, ReadData1=32'h11, ReadData2=32'h22, CtrlIn=12'h041, no WB.
//     - Response: next edge EX_A=32'h11, EX_B=32'h22, EX_Ctrl=12'h041, EX_Valid=1, Stall=0.
//  2. WB bypass:
//     - Stimulus: Rs=16, ReadData1=0, WB_RegWrite=1, WB_WriteRegister=16,
//       WB_WriteData=32'h03C1F0EA.
//     - Response: EX_A=32'h03C1F0EA. Repeat with WB_WriteRegister=0: EX_A=0 for Rs=0.
//  3. Load-use:
//     - Stimulus: lw with Rt=10 (CtrlIn[3]=1) followed by add with Rs=10.
//     - Response: Stall=1 for exactly 1 cycle, one bubble (EX_Valid=0, EX_Ctrl=0), then
//       the add enters EX; StallCount=1.
//  4. ExHold:
//     - Stimulus: assert ExHold for 3 cycles.
//     - Response: EX_* frozen, Stall=1 each cycle, StallCount +3. Flush on cycle 2 gives a
//       bubble that cycle, with Stall=0.
//  5. Async reset:
//     - Stimulus: assert Rst mid-hazard, between edges.
//     - Response: outputs go 0 immediately; after release with no hazard, Stall=0.
//  6. Counter saturation:
//     - Stimulus: CNT_W=2, hold ExHold for 6 cycles.
//     - Response: StallCount sticks at 3.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: register-file read addressing, write-back bypass, load-use
// hazard detection and the ID/EX pipeline register with stall/bubble/flush.
module id_ex_operand_stage #(
  parameter int unsigned CTRL_W      = 12,
  parameter int unsigned MEMREAD_BIT = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic              UsesRt,
  input  logic [31:0]       Imm,
  input  logic [CTRL_W-1:0] CtrlIn,
  output logic [4:0]        ReadRegister1,
  output logic [4:0]        ReadRegister2,
  input  logic [31:0]       ReadData1,
  input  logic [31:0]       ReadData2,
  input  logic              WB_RegWrite,
  input  logic [4:0]        WB_WriteRegister,
  input  logic [31:0]       WB_WriteData,
  input  logic              ExHold,
  input  logic              Flush,
  output logic              Stall,
  output logic              EX_Valid,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rd,
  output logic [31:0]       EX_A,
  output logic [31:0]       EX_B,
  output logic [31:0]       EX_Imm,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t              state_q, state_d;
  logic                ex_valid_q, ex_valid_d;
  logic [4:0]          ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [31:0]         ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
  logic [CTRL_W-1:0]   ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;
  logic [31:0]         op_a, op_b;
  logic                haz, stall;

  // Register 0 reads as zero; a non-zero WB destination implies it is not r0.
  always_comb begin
    op_a = ReadData1;
    if (Rs == '0)
      op_a = '0;
    else if (WB_RegWrite && (WB_WriteRegister == Rs))
      op_a = WB_WriteData;

    op_b = ReadData2;
    if (Rt == '0)
      op_b = '0;
    else if (WB_RegWrite && (WB_WriteRegister == Rt))
      op_b = WB_WriteData;
  end

  always_comb begin
    haz = InValid && ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rt_q != '0) &&
          ((ex_rt_q == Rs) || (UsesRt && (ex_rt_q == Rt)));
    stall = !Flush && (ExHold || haz);
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_ctrl_d  = ex_ctrl_q;
    state_d    = RUN;

    if (Flush || (!ExHold && haz)) begin
      ex_valid_d = 1'b0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
      ex_a_d     = '0;
      ex_b_d     = '0;
      ex_imm_d   = '0;
      ex_ctrl_d  = '0;
    end else if (!ExHold) begin
      ex_valid_d = InValid;
      ex_rs_d    = Rs;
      ex_rt_d    = Rt;
      ex_rd_d    = Rd;
      ex_a_d     = op_a;
      ex_b_d     = op_b;
      ex_imm_d   = Imm;
      ex_ctrl_d  = InValid ? CtrlIn : '0;
    end

    // The inserted bubble clears haz on the following cycle, so BUBBLE lasts one cycle.
    case (state_q)
      RUN:     state_d = (haz && !ExHold && !Flush) ? BUBBLE : RUN;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= RUN;
      ex_valid_q    <= 1'b0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_rd_q       <= '0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_rd_q       <= ex_rd_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ReadRegister1 = Rs;
  assign ReadRegister2 = Rt;
  assign Stall         = stall;
  assign EX_Valid      = ex_valid_q;
  assign EX_Rs         = ex_rs_q;
  assign EX_Rt         = ex_rt_q;
  assign EX_Rd         = ex_rd_q;
  assign EX_A          = ex_a_q;
  assign EX_B          = ex_b_q;
  assign EX_Imm        = ex_imm_q;
  assign EX_Ctrl       = ex_ctrl_q;
  assign StallCount    = stall_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed cycles push expected Stall and
// post-edge ID/EX contents; a monitor pops and compares each cycle.
module tb_id_ex_operand_stage;

  logic        Clk, Rst;
  logic        InValid, UsesRt, WB_RegWrite, ExHold, Flush;
  logic [4:0]  Rs, Rt, Rd, WB_WriteRegister;
  logic [31:0] Imm, ReadData1, ReadData2, WB_WriteData;
  logic [11:0] CtrlIn;

  logic        Stall, EX_Valid;
  logic [4:0]  ReadRegister1, ReadRegister2, EX_Rs, EX_Rt, EX_Rd;
  logic [31:0] EX_A, EX_B, EX_Imm;
  logic [11:0] EX_Ctrl;
  logic [15:0] StallCount;

  logic        s_Stall, s_EX_Valid;
  logic [4:0]  s_rr1, s_rr2, s_EX_Rs, s_EX_Rt, s_EX_Rd;
  logic [31:0] s_EX_A, s_EX_B, s_EX_Imm;
  logic [11:0] s_EX_Ctrl;
  logic [1:0]  s_StallCount;

  id_ex_operand_stage #(.CTRL_W(12), .MEMREAD_BIT(3), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .Rs(Rs), .Rt(Rt), .Rd(Rd), .UsesRt(UsesRt),
    .Imm(Imm), .CtrlIn(CtrlIn), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WB_RegWrite(WB_RegWrite),
    .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData), .ExHold(ExHold),
    .Flush(Flush), .Stall(Stall), .EX_Valid(EX_Valid), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_Rd(EX_Rd), .EX_A(EX_A), .EX_B(EX_B), .EX_Imm(EX_Imm), .EX_Ctrl(EX_Ctrl),
    .StallCount(StallCount)
  );

  id_ex_operand_stage #(.CTRL_W(12), .MEMREAD_BIT(3), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .Rs(Rs), .Rt(Rt), .Rd(Rd), .UsesRt(UsesRt),
    .Imm(Imm), .CtrlIn(CtrlIn), .ReadRegister1(s_rr1), .ReadRegister2(s_rr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WB_RegWrite(WB_RegWrite),
    .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData), .ExHold(ExHold),
    .Flush(Flush), .Stall(s_Stall), .EX_Valid(s_EX_Valid), .EX_Rs(s_EX_Rs), .EX_Rt(s_EX_Rt),
    .EX_Rd(s_EX_Rd), .EX_A(s_EX_A), .EX_B(s_EX_B), .EX_Imm(s_EX_Imm), .EX_Ctrl(s_EX_Ctrl),
    .StallCount(s_StallCount)
  );

  typedef struct {
    int          step;
    logic        stall;
    logic        ev;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] ctrl;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [15:0] cnt;
  } item_t;

  item_t sb[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    step_no   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(input string nm, input int step, input logic [31:0] act,
                              input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s@step%0d: got %h expected %h", nm, step, act, exp);
    else
      pass_cnt++;
  endfunction

  task automatic ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic ut, input logic [31:0] imm,
                     input logic [11:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2);
    InValid = v; Rs = rs; Rt = rt; Rd = rd; UsesRt = ut; Imm = imm; CtrlIn = ctrl;
    ReadData1 = rd1; ReadData2 = rd2;
  endtask

  task automatic wb(input logic w, input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite = w; WB_WriteRegister = r; WB_WriteData = d;
  endtask

  // One cycle: expected Stall for the current inputs, then ID/EX state after the edge.
  task automatic cyc(input logic st, input logic ev, input logic [31:0] a, input logic [31:0] b,
                     input logic [11:0] c, input logic [4:0] rt, input logic [31:0] imm,
                     input logic [15:0] cnt);
    step_no++;
    sb.push_back('{step_no, st, ev, a, b, c, rt, imm, cnt});
    @(posedge Clk);
    #1;
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("Stall", it.step, {31'd0, Stall}, {31'd0, it.stall});
        @(posedge Clk);
        #2;
        chk("EX_Valid", it.step, {31'd0, EX_Valid}, {31'd0, it.ev});
        chk("EX_A", it.step, EX_A, it.a);
        chk("EX_B", it.step, EX_B, it.b);
        chk("EX_Ctrl", it.step, {20'd0, EX_Ctrl}, {20'd0, it.ctrl});
        chk("EX_Rt", it.step, {27'd0, EX_Rt}, {27'd0, it.rt});
        chk("EX_Imm", it.step, EX_Imm, it.imm);
        chk("StallCount", it.step, {16'd0, StallCount}, {16'd0, it.cnt});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    Rst = 1'b1; ExHold = 1'b0; Flush = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
    wb(0, 0, 0);
    #1;
    chk("rst_EX_Valid", 0, {31'd0, EX_Valid}, 32'd0);
    chk("rst_EX_A", 0, EX_A, 32'd0);
    chk("rst_EX_Ctrl", 0, {20'd0, EX_Ctrl}, 32'd0);
    chk("rst_StallCount", 0, {16'd0, StallCount}, 32'd0);
    chk("rst_Stall", 0, {31'd0, Stall}, 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Pass-through.
    ins(1, 8, 9, 3, 1, 32'h1234, 12'h041, 32'h11, 32'h22);
    #1;
    chk("ReadRegister1", 0, {27'd0, ReadRegister1}, 32'd8);
    chk("ReadRegister2", 0, {27'd0, ReadRegister2}, 32'd9);
    cyc(0, 1, 32'h11, 32'h22, 12'h041, 9, 32'h1234, 0);
    // WB bypass on Rs; r0 forced to zero; bypass on Rt.
    ins(1, 16, 9, 3, 1, 0, 12'h002, 0, 32'h5);
    wb(1, 16, 32'h03C1F0EA);
    cyc(0, 1, 32'h03C1F0EA, 32'h5, 12'h002, 9, 0, 0);
    ins(1, 0, 16, 3, 1, 0, 12'h004, 32'hDEAD, 32'h7);
    wb(1, 0, 32'hFFFFFFFF);
    cyc(0, 1, 32'h0, 32'h7, 12'h004, 16, 0, 0);
    ins(1, 5, 16, 3, 1, 0, 12'h010, 32'h1, 32'h2);
    wb(1, 16, 32'hAAAA5555);
    cyc(0, 1, 32'h1, 32'hAAAA5555, 12'h010, 16, 0, 0);

    // Load-use: lw r10, then add using r10 with a concurrent WB to r10.
    ins(1, 2, 10, 0, 0, 32'h4, 12'h008, 32'h100, 0);
    wb(0, 0, 0);
    cyc(0, 1, 32'h100, 32'h0, 12'h008, 10, 32'h4, 0);
    ins(1, 10, 11, 12, 1, 0, 12'h041, 0, 32'h33);
    wb(1, 10, 32'h777);
    cyc(1, 0, 0, 0, 12'h000, 0, 0, 1);
    cyc(0, 1, 32'h777, 32'h33, 12'h041, 11, 0, 1);

    // ExHold for 3 cycles, then release.
    ins(1, 1, 2, 3, 1, 32'h9, 12'h100, 32'h55, 32'h66);
    wb(0, 0, 0);
    ExHold = 1'b1;
    cyc(1, 1, 32'h777, 32'h33, 12'h041, 11, 0, 2);
    cyc(1, 1, 32'h777, 32'h33, 12'h041, 11, 0, 3);
    cyc(1, 1, 32'h777, 32'h33, 12'h041, 11, 0, 4);
    ExHold = 1'b0;
    cyc(0, 1, 32'h55, 32'h66, 12'h100, 2, 32'h9, 4);

    // ExHold for 3 cycles with Flush on the second.
    ins(1, 3, 4, 5, 1, 32'h1, 12'h200, 32'hA, 32'hB);
    ExHold = 1'b1;
    cyc(1, 1, 32'h55, 32'h66, 12'h100, 2, 32'h9, 5);
    Flush = 1'b1;
    cyc(0, 0, 0, 0, 12'h000, 0, 0, 5);
    Flush = 1'b0;
    cyc(1, 0, 0, 0, 12'h000, 0, 0, 6);
    ExHold = 1'b0;
    cyc(0, 1, 32'hA, 32'hB, 12'h200, 4, 32'h1, 6);

    // Flush alone, then an invalid slot (control forced to zero).
    Flush = 1'b1;
    cyc(0, 0, 0, 0, 12'h000, 0, 0, 6);
    Flush = 1'b0;
    ins(0, 3, 4, 5, 1, 32'h1, 12'hFFF, 32'hA, 32'hB);
    cyc(0, 0, 32'hA, 32'hB, 12'h000, 4, 32'h1, 6);

    // Load followed by an Rt match that is not a source: no stall.
    ins(1, 0, 7, 0, 0, 0, 12'h008, 32'h99, 32'h3);
    cyc(0, 1, 32'h0, 32'h3, 12'h008, 7, 0, 6);
    ins(1, 1, 7, 2, 0, 0, 12'h001, 32'h5, 32'h6);
    cyc(0, 1, 32'h5, 32'h6, 12'h001, 7, 0, 6);

    // Async reset in the middle of a load-use stall.
    ins(1, 2, 10, 0, 0, 32'h4, 12'h008, 32'h100, 0);
    cyc(0, 1, 32'h100, 32'h0, 12'h008, 10, 32'h4, 6);
    ins(1, 10, 11, 12, 1, 0, 12'h041, 32'h50, 32'h60);
    #2;
    chk("haz_Stall", 99, {31'd0, Stall}, 32'd1);
    #1;
    Rst = 1'b1;
    #1;
    chk("arst_EX_Valid", 99, {31'd0, EX_Valid}, 32'd0);
    chk("arst_EX_A", 99, EX_A, 32'd0);
    chk("arst_EX_Ctrl", 99, {20'd0, EX_Ctrl}, 32'd0);
    chk("arst_StallCount", 99, {16'd0, StallCount}, 32'd0);
    chk("arst_Stall", 99, {31'd0, Stall}, 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc(0, 1, 32'h50, 32'h60, 12'h041, 11, 0, 0);

    // Counter saturation on the CNT_W=2 instance; main instance counts on.
    ExHold = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 1, 32'h50, 32'h60, 12'h041, 11, 0, 16'(k));
      chk("sat_StallCount", step_no, {30'd0, s_StallCount}, (k > 3) ? 32'd3 : 32'(k));
    end
    ExHold = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
